// File: rtl/ula_issue_pkg.sv
// rtl/ula_issue_pkg.sv - shared constants, types and legality decode for the ula issue controller
package ula_issue_pkg;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = $clog2(NREGS);

   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] F3_ADDSUB  = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL     = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } state_t;

   // Field layout of an RV32 R-type word, MSB first.
   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } instr_t;

   // Only the seven R-type ALU ops the ula implements are accepted;
   // funct7=0100000 is meaningful only as SUB.
   function automatic logic is_legal(input instr_t i);
      logic ok;
      ok = 1'b0;
      if (i.opcode == OPC_OP) begin
         case (i.funct3)
            F3_ADDSUB: ok = (i.funct7 == F7_BASE) || (i.funct7 == F7_ALT);
            F3_SLL,
            F3_XOR,
            F3_SRL,
            F3_OR,
            F3_AND:    ok = (i.funct7 == F7_BASE);
            default:   ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

endpackage

// File: rtl/ula_issue_if.sv
// rtl/ula_issue_if.sv - instruction, ula and debug signal bundle for the issue controller
interface ula_issue_if;
   import ula_issue_pkg::*;

   logic            instr_valid;
   logic            instr_ready;
   logic [31:0]     instr;
   logic [6:0]      ula_opcode;
   logic [2:0]      ula_funct3;
   logic [6:0]      ula_funct7;
   logic [XLEN-1:0] ula_data1;
   logic [XLEN-1:0] ula_data2;
   logic [XLEN-1:0] ula_result;
   logic            done;
   logic            err;
   logic            dbg_we;
   logic [AW-1:0]   dbg_addr;
   logic [XLEN-1:0] dbg_wdata;
   logic [XLEN-1:0] dbg_rdata;

   // Instruction source / debug host side.
   modport master (
      output instr_valid, instr, dbg_we, dbg_addr, dbg_wdata,
      input  instr_ready, done, err, dbg_rdata,
      input  ula_opcode, ula_funct3, ula_funct7, ula_data1, ula_data2, ula_result
   );

   // Issue controller side.
   modport slave (
      input  instr_valid, instr, dbg_we, dbg_addr, dbg_wdata, ula_result,
      output instr_ready, done, err, dbg_rdata,
      output ula_opcode, ula_funct3, ula_funct7, ula_data1, ula_data2
   );

endinterface

// File: rtl/ula.sv
// rtl/ula.sv - combinational RV32 R-type ALU driven by the issue controller
module ula
   import ula_issue_pkg::*;
(
   input  logic [6:0]      opcode,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic [XLEN-1:0] data1_in,
   input  logic [XLEN-1:0] data2_in,
   output logic [XLEN-1:0] data_out
);

   // Operation select on {funct3,funct7}; anything unrecognised yields zero.
   always_comb begin
      data_out = '0;
      if (opcode == OPC_OP) begin
         case ({funct3, funct7})
            {F3_ADDSUB, F7_BASE}: data_out = data1_in + data2_in;
            {F3_ADDSUB, F7_ALT}:  data_out = data1_in - data2_in;
            {F3_SLL,    F7_BASE}: data_out = data1_in << data2_in[4:0];
            {F3_SRL,    F7_BASE}: data_out = data1_in >> data2_in[4:0];
            {F3_XOR,    F7_BASE}: data_out = data1_in ^ data2_in;
            {F3_OR,     F7_BASE}: data_out = data1_in | data2_in;
            {F3_AND,    F7_BASE}: data_out = data1_in & data2_in;
            default:              data_out = '0;
         endcase
      end
   end

endmodule

// File: rtl/ula_issue_regfile.sv
// rtl/ula_issue_regfile.sv - register file with two operand reads, a debug read and one write port
module ula_issue_regfile
   import ula_issue_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   rd_addr1,
   input  logic [AW-1:0]   rd_addr2,
   input  logic [AW-1:0]   dbg_addr,
   output logic [XLEN-1:0] rd_data1,
   output logic [XLEN-1:0] rd_data2,
   output logic [XLEN-1:0] dbg_data,
   input  logic            we,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data
);

   logic [XLEN-1:0] regs [NREGS];

   // Storage: cleared on reset; writes to x0 are dropped so it stays zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (wr_addr != '0)) begin
         regs[wr_addr] <= wr_data;
      end
   end

   assign rd_data1 = (rd_addr1 == '0) ? '0 : regs[rd_addr1];
   assign rd_data2 = (rd_addr2 == '0) ? '0 : regs[rd_addr2];
   assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/ula_issue.sv
// rtl/ula_issue.sv - serialised issue/writeback controller for the ula datapath
module ula_issue
   import ula_issue_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   ula_issue_if.slave bus
);

   state_t          state_q;
   state_t          state_d;
   instr_t          instr_q;
   logic [XLEN-1:0] result_q;
   logic            err_q;
   logic [6:0]      opcode_q;
   logic [2:0]      funct3_q;
   logic [6:0]      funct7_q;
   logic [XLEN-1:0] data1_q;
   logic [XLEN-1:0] data2_q;

   logic            accept;
   logic            legal;
   logic            wb_we;
   logic            dbg_we_ok;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;

   assign accept    = (state_q == ST_IDLE) && bus.instr_valid;
   assign legal     = is_legal(instr_q);
   assign wb_we     = (state_q == ST_WB);
   // Preloads are only honoured while idle, so they can never collide with writeback.
   assign dbg_we_ok = bus.dbg_we && (state_q == ST_IDLE);

   ula_issue_regfile u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_addr1 (instr_q.rs1),
      .rd_addr2 (instr_q.rs2),
      .dbg_addr (bus.dbg_addr),
      .rd_data1 (rs1_val),
      .rd_data2 (rs2_val),
      .dbg_data (bus.dbg_rdata),
      .we       (wb_we || dbg_we_ok),
      .wr_addr  (wb_we ? instr_q.rd : bus.dbg_addr),
      .wr_data  (wb_we ? result_q : bus.dbg_wdata)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: one instruction walks IDLE->READ->EXEC->WB, illegal ones bail out of READ.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.instr_valid) state_d = ST_READ;
         ST_READ: state_d = legal ? ST_EXEC : ST_IDLE;
         ST_EXEC: state_d = ST_WB;
         ST_WB:   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Latch the instruction word on accept; held until the next accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q <= '0;
      end else if (accept) begin
         instr_q <= instr_t'(bus.instr);
      end
   end

   // Drive the ula for EXEC; these registers hold their value in every other state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opcode_q <= '0;
         funct3_q <= '0;
         funct7_q <= '0;
         data1_q  <= '0;
         data2_q  <= '0;
      end else if ((state_q == ST_READ) && legal) begin
         opcode_q <= instr_q.opcode;
         funct3_q <= instr_q.funct3;
         funct7_q <= instr_q.funct7;
         data1_q  <= rs1_val;
         data2_q  <= rs2_val;
      end
   end

   // Capture the combinational ula result at the end of EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
      end else if (state_q == ST_EXEC) begin
         result_q <= bus.ula_result;
      end
   end

   // Error pulse lands in the cycle the FSM re-enters IDLE after an illegal READ.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= (state_q == ST_READ) && !legal;
      end
   end

   assign bus.instr_ready = (state_q == ST_IDLE);
   assign bus.done        = (state_q == ST_WB);
   assign bus.err         = err_q;
   assign bus.ula_opcode  = opcode_q;
   assign bus.ula_funct3  = funct3_q;
   assign bus.ula_funct7  = funct7_q;
   assign bus.ula_data1   = data1_q;
   assign bus.ula_data2   = data2_q;

endmodule
